// File: rtl/imem_boot_loader.sv
// Byte-stream boot loader: packs big-endian bytes into 32-bit IMEM words and holds the core
// in reset until the whole image is written. Define BOOT_CHECKSUM_EN for a trailing checksum byte.
`timescale 1ns/1ps
module imem_boot_loader #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    input  logic                  reload,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_waddr,
    output logic [31:0]           imem_wdata,
    output logic                  cpu_nrst,
    output logic                  busy,
    output logic                  error
);

`ifdef BOOT_CHECKSUM_EN
    typedef enum logic [2:0] {
        S_HDR_HI = 3'd0,
        S_HDR_LO = 3'd1,
        S_DATA   = 3'd2,
        S_CSUM   = 3'd3,
        S_DONE   = 3'd4,
        S_ERROR  = 3'd5
    } state_t;
`else
    typedef enum logic [2:0] {
        S_HDR_HI = 3'd0,
        S_HDR_LO = 3'd1,
        S_DATA   = 3'd2,
        S_DONE   = 3'd4,
        S_ERROR  = 3'd5
    } state_t;
`endif

    localparam int          CW       = ADDR_WIDTH + 1;
    localparam logic [16:0] CAPACITY = 17'd1 << ADDR_WIDTH;

    state_t                  state_q;
    logic [15:0]             n_q;
    logic [1:0]              byte_cnt_q;
    logic [CW-1:0]           word_cnt_q;
    logic [23:0]             asm_q;
    logic                    imem_we_q;
    logic [ADDR_WIDTH-1:0]   imem_waddr_q;
    logic [31:0]             imem_wdata_q;
    logic                    cpu_nrst_q;
    logic                    busy_q;
    logic                    error_q;

    logic                    accept;
    logic [16:0]             n_hdr_d;
    logic                    last_word_d;
    logic [31:0]             word_d;

`ifdef BOOT_CHECKSUM_EN
    logic [7:0]              csum_q;
    logic [7:0]              csum_d;
    assign csum_d = csum_q + rx_data;
`endif

    // A byte transfers on a rising edge with rx_valid && rx_ready; rx_ready is a pure
    // function of state and never looks at rx_valid.
    assign rx_ready    = (state_q != S_DONE) && (state_q != S_ERROR);
    assign accept      = rx_valid && rx_ready;
    assign n_hdr_d     = {1'b0, n_q[15:8], rx_data};
    assign last_word_d = (17'(word_cnt_q) + 17'd1) == {1'b0, n_q};
    assign word_d      = {asm_q, rx_data};

    assign imem_we    = imem_we_q;
    assign imem_waddr = imem_waddr_q;
    assign imem_wdata = imem_wdata_q;
    assign cpu_nrst   = cpu_nrst_q;
    assign busy       = busy_q;
    assign error      = error_q;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q      <= S_HDR_HI;
            n_q          <= '0;
            byte_cnt_q   <= '0;
            word_cnt_q   <= '0;
            asm_q        <= '0;
            imem_we_q    <= 1'b0;
            imem_waddr_q <= '0;
            imem_wdata_q <= '0;
            cpu_nrst_q   <= 1'b0;
            busy_q       <= 1'b1;
            error_q      <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
            csum_q       <= '0;
`endif
        end else begin
            imem_we_q <= 1'b0;
            case (state_q)
                S_HDR_HI: begin
                    if (accept) begin
                        n_q[15:8] <= rx_data;
                        state_q   <= S_HDR_LO;
                    end
                end
                S_HDR_LO: begin
                    if (accept) begin
                        n_q[7:0] <= rx_data;
                        if (n_hdr_d == 17'd0) begin
`ifdef BOOT_CHECKSUM_EN
                            state_q    <= S_CSUM;
`else
                            state_q    <= S_DONE;
                            cpu_nrst_q <= 1'b1;
                            busy_q     <= 1'b0;
`endif
                        end else if (n_hdr_d > CAPACITY) begin
                            state_q <= S_ERROR;
                            error_q <= 1'b1;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (accept) begin
                        byte_cnt_q <= byte_cnt_q + 2'd1;
                        asm_q      <= {asm_q[15:0], rx_data};
`ifdef BOOT_CHECKSUM_EN
                        csum_q     <= csum_d;
`endif
                        if (byte_cnt_q == 2'd3) begin
                            imem_we_q    <= 1'b1;
                            imem_waddr_q <= word_cnt_q[ADDR_WIDTH-1:0];
                            imem_wdata_q <= word_d;
                            word_cnt_q   <= word_cnt_q + 1'b1;
                            // The last strobe and the core release land in the same cycle.
                            if (last_word_d) begin
`ifdef BOOT_CHECKSUM_EN
                                state_q    <= S_CSUM;
`else
                                state_q    <= S_DONE;
                                cpu_nrst_q <= 1'b1;
                                busy_q     <= 1'b0;
`endif
                            end
                        end
                    end
                end
`ifdef BOOT_CHECKSUM_EN
                S_CSUM: begin
                    if (accept) begin
                        busy_q <= 1'b0;
                        if (csum_d == 8'd0) begin
                            state_q    <= S_DONE;
                            cpu_nrst_q <= 1'b1;
                        end else begin
                            state_q <= S_ERROR;
                            error_q <= 1'b1;
                        end
                    end
                end
`endif
                S_DONE, S_ERROR: begin
                    if (reload) begin
                        state_q    <= S_HDR_HI;
                        n_q        <= '0;
                        byte_cnt_q <= '0;
                        word_cnt_q <= '0;
                        asm_q      <= '0;
                        cpu_nrst_q <= 1'b0;
                        busy_q     <= 1'b1;
                        error_q    <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
                        csum_q     <= '0;
`endif
                    end
                end
                default: state_q <= S_HDR_HI;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Bench for imem_boot_loader: a cycle-vector table for the main flow plus hand sequences
// for gaps, mid-load reset, checksum and full-capacity loads on a 4-word instance.
`timescale 1ns/1ps
module tb_imem_boot_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        nrst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        reload;
    logic        imem_we;
    logic [7:0]  imem_waddr;
    logic [31:0] imem_wdata;
    logic        cpu_nrst;
    logic        busy;
    logic        error;

    logic [7:0]  s_rx_data;
    logic        s_rx_valid;
    logic        s_rx_ready;
    logic        s_reload;
    logic        s_imem_we;
    logic [1:0]  s_imem_waddr;
    logic [31:0] s_imem_wdata;
    logic        s_cpu_nrst;
    logic        s_busy;
    logic        s_error;

    imem_boot_loader #(.ADDR_WIDTH(8)) u_dut (
        .clk(clk), .nrst(nrst), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .reload(reload), .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
        .cpu_nrst(cpu_nrst), .busy(busy), .error(error)
    );

    imem_boot_loader #(.ADDR_WIDTH(2)) u_dut_small (
        .clk(clk), .nrst(nrst), .rx_data(s_rx_data), .rx_valid(s_rx_valid), .rx_ready(s_rx_ready),
        .reload(s_reload), .imem_we(s_imem_we), .imem_waddr(s_imem_waddr), .imem_wdata(s_imem_wdata),
        .cpu_nrst(s_cpu_nrst), .busy(s_busy), .error(s_error)
    );

    int          errors = 0;
    int          checks = 0;
    int          acc_cnt = 0;
    logic [47:0] exp_q[$];
    logic [47:0] exp_s_q[$];
    logic [31:0] img[16];

    typedef struct {
        logic        v;
        logic [7:0]  d;
        logic        rl;
        logic        rdy;
        logic        we;
        logic [7:0]  addr;
        logic [31:0] wd;
        logic        cpu;
        logic        bsy;
        logic        err;
    } vec_t;
    vec_t tbl[$];

    function automatic vec_t mk(input logic v, input logic [7:0] d, input logic rl,
                                input logic rdy, input logic we, input logic [7:0] addr,
                                input logic [31:0] wd, input logic cpu, input logic bsy,
                                input logic err);
        vec_t r;
        r.v = v; r.d = d; r.rl = rl; r.rdy = rdy; r.we = we; r.addr = addr;
        r.wd = wd; r.cpu = cpu; r.bsy = bsy; r.err = err;
        return r;
    endfunction

    task automatic check(input string name, input logic [47:0] act, input logic [47:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Scoreboard: every write strobe must match the head of the expected queue.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (imem_we === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_write: addr=%0h data=%0h required=none", imem_waddr, imem_wdata);
                end else begin
                    check("imem_write", {8'h0, imem_waddr, imem_wdata}, exp_q.pop_front());
                end
            end
            if (s_imem_we === 1'b1) begin
                if (exp_s_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_small_write: addr=%0h data=%0h required=none", s_imem_waddr, s_imem_wdata);
                end else begin
                    check("small_imem_write", {14'h0, s_imem_waddr, s_imem_wdata}, exp_s_q.pop_front());
                end
            end
        end
    end

    always @(posedge clk) begin
        if (rx_valid && rx_ready) acc_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic get_rdy(input int sel);
        return (sel == 0) ? rx_ready : s_rx_ready;
    endfunction

    task automatic drive(input int sel, input logic v, input logic [7:0] d);
        if (sel == 0) begin rx_valid = v; rx_data = d; end
        else begin s_rx_valid = v; s_rx_data = d; end
    endtask

    task automatic set_reload(input int sel, input logic r);
        if (sel == 0) reload = r;
        else s_reload = r;
    endtask

    task automatic pulse_reload(input int sel);
        @(negedge clk);
        set_reload(sel, 1'b1);
        @(negedge clk);
        set_reload(sel, 1'b0);
    endtask

    task automatic send_byte(input int sel, input logic [7:0] b, input int gap);
        int t;
        for (int g = 0; g < gap; g++) @(negedge clk);
        @(negedge clk);
        drive(sel, 1'b1, b);
        t = 0;
        while (!get_rdy(sel) && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!get_rdy(sel)) begin
            checks++; errors++;
            $display("FAIL accept_timeout: sel=%0d byte=%0h rx_ready=0 required=1", sel, b);
            drive(sel, 1'b0, b);
        end else begin
            @(posedge clk);
            #1;
            drive(sel, 1'b0, b);
        end
    endtask

    task automatic send_image(input int sel, input int n, input int maxgap, input logic [7:0] bad,
                              input logic hold_rld);
        logic [7:0] sum;
        logic [7:0] b;
        logic [7:0] csum_b;
        sum = 8'h0;
        send_byte(sel, 8'(n >> 8), int'($urandom_range(0, maxgap)));
        send_byte(sel, 8'(n), int'($urandom_range(0, maxgap)));
        if (hold_rld) set_reload(sel, 1'b1);
        for (int i = 0; i < n; i++) begin
            if (sel == 0) exp_q.push_back({8'h0, 8'(i), img[i]});
            else exp_s_q.push_back({14'h0, 2'(i), img[i]});
            for (int k = 0; k < 4; k++) begin
                b = img[i][31-8*k -: 8];
                sum = sum + b;
                if (hold_rld && i == n - 1 && k == 2) set_reload(sel, 1'b0);
                send_byte(sel, b, int'($urandom_range(0, maxgap)));
            end
        end
        csum_b = 8'h0 - sum + bad;
`ifdef BOOT_CHECKSUM_EN
        send_byte(sel, csum_b, int'($urandom_range(0, maxgap)));
`endif
    endtask

    initial begin
        int base;
        nrst = 1'b1; rx_valid = 1'b0; rx_data = 8'h0; reload = 1'b0;
        s_rx_valid = 1'b0; s_rx_data = 8'h0; s_reload = 1'b0;

        // Clock/reset
        #2 nrst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset rx_ready", 48'(rx_ready), 48'd1);
        check("reset imem_we", 48'(imem_we), 48'd0);
        check("reset waddr_wdata", {8'h0, imem_waddr, imem_wdata}, 48'd0);
        check("reset cpu_nrst", 48'(cpu_nrst), 48'd0);
        check("reset busy", 48'(busy), 48'd1);
        check("reset error", 48'(error), 48'd0);
        check("reset small busy", 48'(s_busy), 48'd1);
        @(negedge clk);
        nrst = 1'b1;

        // Cycle table: basic load, reload, oversize header, N=0, N=capacity header.
        exp_q.push_back({8'h0, 8'h00, 32'h24080005});
        exp_q.push_back({8'h0, 8'h01, 32'h0000000D});
        tbl.push_back(mk(1, 8'h00, 0, 1, 0, 8'h00, 32'h0, 0, 1, 0));
        tbl.push_back(mk(1, 8'h02, 0, 1, 0, 8'h00, 32'h0, 0, 1, 0));
        tbl.push_back(mk(1, 8'h24, 0, 1, 0, 8'h00, 32'h0, 0, 1, 0));
        tbl.push_back(mk(1, 8'h08, 0, 1, 0, 8'h00, 32'h0, 0, 1, 0));
        tbl.push_back(mk(1, 8'h00, 0, 1, 0, 8'h00, 32'h0, 0, 1, 0));
        tbl.push_back(mk(1, 8'h05, 0, 1, 1, 8'h00, 32'h24080005, 0, 1, 0));
        tbl.push_back(mk(1, 8'h00, 0, 1, 0, 8'h00, 32'h24080005, 0, 1, 0));
        tbl.push_back(mk(1, 8'h00, 0, 1, 0, 8'h00, 32'h24080005, 0, 1, 0));
        tbl.push_back(mk(1, 8'h00, 0, 1, 0, 8'h00, 32'h24080005, 0, 1, 0));
`ifdef BOOT_CHECKSUM_EN
        tbl.push_back(mk(1, 8'h0D, 0, 1, 1, 8'h01, 32'h0000000D, 0, 1, 0));
        tbl.push_back(mk(1, 8'hC2, 0, 0, 0, 8'h01, 32'h0000000D, 1, 0, 0));
`else
        tbl.push_back(mk(1, 8'h0D, 0, 0, 1, 8'h01, 32'h0000000D, 1, 0, 0));
`endif
        tbl.push_back(mk(1, 8'h55, 0, 0, 0, 8'h01, 32'h0000000D, 1, 0, 0));
        tbl.push_back(mk(0, 8'h00, 1, 1, 0, 8'h01, 32'h0000000D, 0, 1, 0));
        tbl.push_back(mk(1, 8'h01, 0, 1, 0, 8'h01, 32'h0000000D, 0, 1, 0));
        tbl.push_back(mk(1, 8'h01, 0, 0, 0, 8'h01, 32'h0000000D, 0, 0, 1));
        tbl.push_back(mk(1, 8'h33, 0, 0, 0, 8'h01, 32'h0000000D, 0, 0, 1));
        tbl.push_back(mk(0, 8'h00, 1, 1, 0, 8'h01, 32'h0000000D, 0, 1, 0));
        tbl.push_back(mk(1, 8'h00, 0, 1, 0, 8'h01, 32'h0000000D, 0, 1, 0));
`ifdef BOOT_CHECKSUM_EN
        tbl.push_back(mk(1, 8'h00, 0, 1, 0, 8'h01, 32'h0000000D, 0, 1, 0));
`endif
        tbl.push_back(mk(1, 8'h00, 0, 0, 0, 8'h01, 32'h0000000D, 1, 0, 0));
        tbl.push_back(mk(0, 8'h00, 1, 1, 0, 8'h01, 32'h0000000D, 0, 1, 0));
        tbl.push_back(mk(1, 8'h01, 0, 1, 0, 8'h01, 32'h0000000D, 0, 1, 0));
        tbl.push_back(mk(1, 8'h00, 0, 1, 0, 8'h01, 32'h0000000D, 0, 1, 0));

        foreach (tbl[i]) begin
            @(negedge clk);
            rx_valid = tbl[i].v; rx_data = tbl[i].d; reload = tbl[i].rl;
            @(posedge clk);
            #1;
            check($sformatf("row%0d rx_ready", i), 48'(rx_ready), 48'(tbl[i].rdy));
            check($sformatf("row%0d imem_we", i), 48'(imem_we), 48'(tbl[i].we));
            check($sformatf("row%0d waddr_wdata", i), {8'h0, imem_waddr, imem_wdata},
                  {8'h0, tbl[i].addr, tbl[i].wd});
            check($sformatf("row%0d cpu_nrst", i), 48'(cpu_nrst), 48'(tbl[i].cpu));
            check($sformatf("row%0d busy", i), 48'(busy), 48'(tbl[i].bsy));
            check($sformatf("row%0d error", i), 48'(error), 48'(tbl[i].err));
        end
        @(negedge clk);
        rx_valid = 1'b0; reload = 1'b0;

        // Reset mid-load: abandon a 2-word image after 6 data bytes.
        nrst = 1'b0;
        @(negedge clk);
        nrst = 1'b1;
        exp_q.push_back({8'h0, 8'h00, 32'h11223344});
        send_byte(0, 8'h00, 0);
        send_byte(0, 8'h02, 0);
        send_byte(0, 8'h11, 0);
        send_byte(0, 8'h22, 0);
        send_byte(0, 8'h33, 0);
        send_byte(0, 8'h44, 0);
        send_byte(0, 8'h55, 0);
        send_byte(0, 8'h66, 0);
        @(negedge clk);
        nrst = 1'b0;
        #1;
        check("midreset rx_ready", 48'(rx_ready), 48'd1);
        check("midreset waddr_wdata", {8'h0, imem_waddr, imem_wdata}, 48'd0);
        check("midreset cpu_nrst", 48'(cpu_nrst), 48'd0);
        check("midreset busy", 48'(busy), 48'd1);
        check("midreset error", 48'(error), 48'd0);
        @(negedge clk);
        nrst = 1'b1;
        img[0] = 32'h11223344;
        img[1] = 32'h55667788;
        send_image(0, 2, 0, 8'h00, 1'b0);
        check("resend cpu_nrst", 48'(cpu_nrst), 48'd1);
        check("resend busy", 48'(busy), 48'd0);

        // Gapped 3-word load with random rx_valid gaps.
        pulse_reload(0);
        check("reload_done cpu_nrst", 48'(cpu_nrst), 48'd0);
        check("reload_done busy", 48'(busy), 48'd1);
        img[0] = 32'hDEADBEEF;
        img[1] = 32'h01234567;
        img[2] = 32'hA5A55A5A;
        base = acc_cnt;
        send_image(0, 3, 3, 8'h00, 1'b0);
        check("gapped cpu_nrst", 48'(cpu_nrst), 48'd1);
        check("gapped rx_ready", 48'(rx_ready), 48'd0);
        @(negedge clk);
        rx_valid = 1'b1; rx_data = 8'hAA;
        repeat (4) @(negedge clk);
        rx_valid = 1'b0;
`ifdef BOOT_CHECKSUM_EN
        check("gapped accepted_bytes", 48'(acc_cnt - base), 48'd15);
`else
        check("gapped accepted_bytes", 48'(acc_cnt - base), 48'd14);
`endif
        check("gapped still_done", 48'(cpu_nrst), 48'd1);

`ifdef BOOT_CHECKSUM_EN
        // Checksum good (F6) then bad (F7) on 00 01 | 01 02 03 04.
        pulse_reload(0);
        img[0] = 32'h01020304;
        send_image(0, 1, 0, 8'h00, 1'b0);
        check("csum_good cpu_nrst", 48'(cpu_nrst), 48'd1);
        check("csum_good error", 48'(error), 48'd0);
        pulse_reload(0);
        send_image(0, 1, 0, 8'h01, 1'b0);
        check("csum_bad error", 48'(error), 48'd1);
        check("csum_bad cpu_nrst", 48'(cpu_nrst), 48'd0);
        check("csum_bad busy", 48'(busy), 48'd0);
        check("csum_bad last_write", {8'h0, imem_waddr, imem_wdata}, {8'h0, 8'h00, 32'h01020304});
`endif

        // 4-word instance: N=5 oversize, then N=4 full load with reload held during DATA.
        send_byte(1, 8'h00, 0);
        send_byte(1, 8'h05, 0);
        check("small_oversize error", 48'(s_error), 48'd1);
        check("small_oversize rx_ready", 48'(s_rx_ready), 48'd0);
        check("small_oversize cpu_nrst", 48'(s_cpu_nrst), 48'd0);
        pulse_reload(1);
        check("small_reload error", 48'(s_error), 48'd0);
        check("small_reload busy", 48'(s_busy), 48'd1);
        img[0] = 32'h10000001;
        img[1] = 32'h20000002;
        img[2] = 32'h30000003;
        img[3] = 32'h40000004;
        send_image(1, 4, 1, 8'h00, 1'b1);
        check("small_full cpu_nrst", 48'(s_cpu_nrst), 48'd1);
        check("small_full busy", 48'(s_busy), 48'd0);
        check("small_full error", 48'(s_error), 48'd0);
        check("small_full last_addr", {14'h0, s_imem_waddr, s_imem_wdata}, {14'h0, 2'd3, 32'h40000004});

        repeat (3) @(negedge clk);
        check("exp_q drained", 48'(exp_q.size()), 48'd0);
        check("exp_s_q drained", 48'(exp_s_q.size()), 48'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
